// File: rtl/mux_pkg.sv
// Shared constants and helpers for the registered round-robin multiplexer.
package mux_pkg;

    // Values of the mode input.
    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Index width that stays at least one bit wide, so a single-channel build still elaborates.
    function automatic int clog2_safe(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_mux_reg_arbiter.sv
// Combinational rotating-priority arbiter.
// The request at index ptr has the highest priority. Priority then falls through
// ptr+1, ptr+2, ... and wraps modulo N_CH.
module rr_arbiter #(
    parameter int N_CH  = 4,
    parameter int SEL_W = 2
) (
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] grant_idx,
    output logic             grant_valid
);

    // Scan from ptr and take the first active request. The modulo makes the wrap
    // explicit, which also covers non-power-of-2 channel counts.
    // NOTE: every output gets a default before the loop, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        int               idx;
        logic [SEL_W-1:0] idx_s;
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        idx_s       = '0;
        for (int k = 0; k < N_CH; k++) begin
            idx   = (int'(ptr) + k) % N_CH;
            idx_s = SEL_W'(idx);
            if (!grant_valid && req[idx_s]) begin
                grant_valid = 1'b1;
                grant_idx   = idx_s;
            end
        end
    end

endmodule

// File: rtl/rr_mux_reg.sv
// Registered N-channel multiplexer with per-channel valid/ready handshakes.
// The channel is chosen either by a fixed select input or by round-robin over the valid requesters.
module rr_mux_reg
    import mux_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int WIDTH = 2,
    parameter int SEL_W = clog2_safe(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
    input  logic [N_CH*WIDTH-1:0] in_data,
    input  logic [N_CH-1:0]       in_valid,
    output logic [N_CH-1:0]       in_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SEL_W-1:0]      out_ch
);

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0] out_ch_q,   out_ch_d;
    logic             out_valid_q, out_valid_d;
    logic [SEL_W-1:0] rr_ptr_q,   rr_ptr_d;

    logic [WIDTH-1:0] ch_data [N_CH];
    logic [SEL_W-1:0] arb_idx;
    logic             arb_valid;
    logic             fix_valid;
    logic [SEL_W-1:0] grant_idx;
    logic             grant_valid;
    logic             load_en;
    logic             load;

    // Split the packed input bus into one word per channel.
    for (genvar i = 0; i < N_CH; i++) begin : g_unpack
        assign ch_data[i] = in_data[i*WIDTH +: WIDTH];
    end

    rr_arbiter #(
        .N_CH  (N_CH),
        .SEL_W (SEL_W)
    ) u_arbiter (
        .req         (in_valid),
        .ptr         (rr_ptr_q),
        .grant_idx   (arb_idx),
        .grant_valid (arb_valid)
    );

    // Fixed-mode grant: the selected channel wins only if it exists and is requesting.
    always_comb begin
        fix_valid = 1'b0;
        if (int'(sel) < N_CH) begin
            fix_valid = in_valid[sel];
        end
    end

    // Choose the grant source from the current mode. The output register is not involved.
    always_comb begin
        if (mode == MODE_RR) begin
            grant_idx   = arb_idx;
            grant_valid = arb_valid;
        end else begin
            grant_idx   = sel;
            grant_valid = fix_valid;
        end
    end

    // The output register can take a new word when it is empty or being drained this cycle.
    assign load_en = !out_valid_q || out_ready;
    assign load    = load_en && grant_valid;

    // One-hot accept toward the granted producer.
    // NOTE: in_ready is gated with rst_n because the empty register would otherwise advertise readiness during reset.
    always_comb begin
        in_ready = '0;
        if (rst_n && load) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    // Next state: load the granted word, drain to empty, or hold.
    always_comb begin
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        rr_ptr_d    = rr_ptr_q;
        if (load) begin
            out_data_d  = ch_data[grant_idx];
            out_ch_d    = grant_idx;
            out_valid_d = 1'b1;
            if (mode == MODE_RR) begin
                rr_ptr_d = (int'(grant_idx) == N_CH - 1) ? '0 : grant_idx + 1'b1;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Output register and round-robin pointer. Reset clears them all, so the first scan after reset starts at channel 0.
    // NOTE: sequential state uses non-blocking assignments, so every register samples the pre-edge value of every _d.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            rr_ptr_q    <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_rr_mux_reg.sv
// Bench for rr_mux_reg with N_CH=4 and WIDTH=2.
// A transaction-level model is checked against the DUT on every falling edge.
// Directed vectors carry hand-computed literal expectations.
module tb_rr_mux_reg;

    localparam int N_CH  = 4;
    localparam int WIDTH = 2;
    localparam int SEL_W = 2;

    logic                  clk       = 1'b0;
    logic                  rst_n     = 1'b0;
    logic                  mode      = 1'b0;
    logic [SEL_W-1:0]      sel       = '0;
    logic [N_CH*WIDTH-1:0] in_data   = 8'b10_11_01_00;
    logic [N_CH-1:0]       in_valid  = 4'b1111;
    logic [N_CH-1:0]       in_ready;
    logic [WIDTH-1:0]      out_data;
    logic                  out_valid;
    logic                  out_ready = 1'b1;
    logic [SEL_W-1:0]      out_ch;

    int n_tests = 0;
    int n_fail  = 0;

    rr_mux_reg #(
        .N_CH  (N_CH),
        .WIDTH (WIDTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    bit m_valid = 1'b0;
    int m_data  = 0;
    int m_ch    = 0;
    int m_ptr   = 0;

    // Winning channel under the arbitration rules, or -1 when nobody wins.
    function automatic int model_grant(input bit md, input int s, input logic [N_CH-1:0] v, input int ptr);
        int c;
        if (md == 1'b0) begin
            if (s < N_CH && ((v >> s) & 1) != 0) return s;
            return -1;
        end
        for (int k = 0; k < N_CH; k++) begin
            c = (ptr + k) % N_CH;
            if (((v >> c) & 1) != 0) return c;
        end
        return -1;
    endfunction

    function automatic int chan_word(input int c);
        logic [N_CH*WIDTH-1:0] t;
        t = in_data >> (c * WIDTH);
        return int'(t[WIDTH-1:0]);
    endfunction

    function automatic int exp_ready();
        int g;
        if (!rst_n) return 0;
        g = model_grant(mode, int'(sel), in_valid, m_ptr);
        if (g >= 0 && (!m_valid || out_ready)) return 1 << g;
        return 0;
    endfunction

    // Advance the model on each clock edge, and clear it on reset.
    always @(posedge clk or negedge rst_n) begin
        int g;
        if (!rst_n) begin
            m_valid = 1'b0;
            m_data  = 0;
            m_ch    = 0;
            m_ptr   = 0;
        end else begin
            g = model_grant(mode, int'(sel), in_valid, m_ptr);
            if (g >= 0 && (!m_valid || out_ready)) begin
                m_data  = chan_word(g);
                m_ch    = g;
                m_valid = 1'b1;
                if (mode) m_ptr = (g + 1) % N_CH;
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    // Compare the DUT against the model on every falling edge.
    // The same process also checks that producers hold their data until accepted.
    logic [N_CH-1:0]       prev_v = '0;
    logic [N_CH-1:0]       prev_r = '0;
    logic [N_CH*WIDTH-1:0] prev_d = '0;

    always @(negedge clk) begin
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("out_data", 32'(out_data), 32'(m_data));
        check("out_ch", 32'(out_ch), 32'(m_ch));
        check("in_ready", 32'(in_ready), 32'(exp_ready()));
        for (int i = 0; i < N_CH; i++) begin
            if (prev_v[i] && !prev_r[i] && in_valid[i]) begin
                check("producer_hold", 32'(in_data[i*WIDTH +: WIDTH]), 32'(prev_d[i*WIDTH +: WIDTH]));
            end
        end
        prev_v = in_valid;
        prev_r = in_ready;
        prev_d = in_data;
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    int seq_a [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int seq_b [4] = '{1, 3, 1, 3};

    initial begin
        // Reset is held with every channel requesting.
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'b0);
        check("rst_out_data", 32'(out_data), 32'b00);
        check("rst_in_ready", 32'(in_ready), 32'b0000);

        // Release reset in fixed mode with sel=2. The first transfer shows one edge later.
        tick();
        mode  = 1'b0;
        sel   = 2'd2;
        rst_n = 1'b1;
        @(negedge clk);
        check("fix2_in_ready", 32'(in_ready), 32'b0100);
        check("fix2_pre_valid", 32'(out_valid), 32'b0);
        tick();
        check("fix2_out_valid", 32'(out_valid), 32'b1);
        check("fix2_out_data", 32'(out_data), 32'b11);
        check("fix2_out_ch", 32'(out_ch), 32'd2);

        // Switch to sel=3 while words keep flowing.
        sel = 2'd3;
        @(negedge clk);
        check("fix3_in_ready", 32'(in_ready), 32'b1000);
        tick();
        check("fix3_out_data", 32'(out_data), 32'b10);
        check("fix3_out_ch", 32'(out_ch), 32'd3);

        // Channel 1 is selected but idle, so nothing is granted and the register drains.
        sel      = 2'd1;
        in_valid = 4'b1101;
        @(negedge clk);
        check("nogrant_in_ready", 32'(in_ready), 32'b0000);
        check("nogrant_still_valid", 32'(out_valid), 32'b1);
        tick();
        check("drain_out_valid", 32'(out_valid), 32'b0);
        check("drain_hold_data", 32'(out_data), 32'b10);
        check("drain_hold_ch", 32'(out_ch), 32'd3);

        // Round-robin over all four channels, with back-to-back loads and no bubbles.
        mode     = 1'b1;
        in_valid = 4'b1111;
        @(negedge clk);
        check("rr_first_in_ready", 32'(in_ready), 32'b0001);
        for (int k = 0; k < 8; k++) begin
            tick();
            check("rr_all_valid", 32'(out_valid), 32'b1);
            check("rr_all_ch", 32'(out_ch), 32'(seq_a[k]));
        end

        // Round-robin over a sparse set of requesters.
        in_valid = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("rr_sparse_ch", 32'(out_ch), 32'(seq_b[k]));
        end

        // Stall with a word held. The pointer must not advance while stalled.
        in_valid = 4'b1111;
        tick();
        check("stall_load_ch", 32'(out_ch), 32'd0);
        out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("stall_in_ready", 32'(in_ready), 32'b0000);
            tick();
            check("stall_hold_valid", 32'(out_valid), 32'b1);
            check("stall_hold_ch", 32'(out_ch), 32'd0);
            check("stall_hold_data", 32'(out_data), 32'b00);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("unstall_in_ready", 32'(in_ready), 32'b0010);
        tick();
        check("unstall_ch", 32'(out_ch), 32'd1);
        check("unstall_data", 32'(out_data), 32'b01);

        // Assert reset mid-stream with the pointer at 2. out_valid must drop at once, without a clock edge.
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(out_valid), 32'b0);
        check("async_rst_in_ready", 32'(in_ready), 32'b0000);
        check("async_rst_data", 32'(out_data), 32'b00);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 32'b0001);
        tick();
        check("post_rst_valid", 32'(out_valid), 32'b1);
        check("post_rst_ch", 32'(out_ch), 32'd0);

        tick();
        tick();
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Bound the run in case the stimulus ever stalls.
    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/rr_mux_reg.md
Name: rr_mux_reg

Overview:
Parametrised, registered N-channel multiplexer; successor to the combinational 4:1 2-bit procedural mux.
Channel selection is either fixed (external select) or round-robin over valid requesters.
Each input channel has a valid/ready handshake; the output is a single registered stage with a valid/ready handshake.
Sits between multiple producers and one shared downstream consumer.

Parameters:
N_CH, 4, number of input channels (2..16)
WIDTH, 2, data width per channel
SEL_W, $clog2(N_CH), select/channel-index width (derived; do not override)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
mode  input  1  0 = fixed select, 1 = round-robin
sel  input  SEL_W  channel index used in fixed mode
in_data  input  N_CH*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH]
in_valid  input  N_CH  per-channel request
in_ready  output  N_CH  per-channel accept (combinational)
out_data  output  WIDTH  registered selected data
out_valid  output  1  output register holds data
out_ready  input  1  downstream accept
out_ch  output  SEL_W  index of the channel that supplied out_data

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_ch=0, rr_ptr=0. in_ready is all-zero while rst_n=0.
- load_en = !out_valid | out_ready. Load happens when load_en and a grant exist.
- Fixed mode (mode=0):
  - grant = sel when in_valid[sel]=1 and sel<N_CH; otherwise no grant.
  - rr_ptr is not modified.
- Round-robin mode (mode=1):
  - grant = first i with in_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo N_CH.
  - On a load, rr_ptr <= (grant+1) mod N_CH. Wrap from N_CH-1 goes to 0; non-power-of-2 N_CH wraps explicitly.
- in_ready[i] = load_en & grant_valid & (grant==i). At most one bit is set; it is never set for a channel with in_valid=0.
- Transfer on input i when in_valid[i] & in_ready[i]. On the same edge: out_data <= channel i data, out_ch <= i, out_valid <= 1.
- Latency: 1 cycle from input transfer to out_valid.
- Throughput: 1 transfer per cycle when out_ready=1 continuously.
- Drain without refill (out_valid & out_ready & no grant): out_valid <= 0. out_data and out_ch hold their last values.
- Stall (out_valid & !out_ready): out_data, out_ch, out_valid hold; in_ready is all-zero.
- Simultaneous drain and load: the new word replaces the old in the same cycle. No bubble, no loss.
- mode and sel are sampled every cycle. A change affects only the next arbitration; a held output word is never altered.
- Reset mid-transfer: the held word is discarded; the next RR scan starts at channel 0.
- Producers must hold in_data/in_valid stable until accepted. The block does not require this for correctness, but the bench checks it.

Decomposition:
- Shared package (mux_pkg):
  - MODE_FIXED=1'b0 and MODE_RR=1'b1 localparams.
  - clog2-safe width helper when N_CH=1 is ever allowed.
- One sub-module, rr_arbiter: inputs req[N_CH] and ptr; outputs grant_idx and grant_valid. Purely combinational priority rotate.
- Top-level rr_mux_reg owns rr_ptr, the output register and the handshake logic.

Test Plan (N_CH=4, WIDTH=2):
1. rst_n=0 with in_valid=4'b1111 -> out_valid=0, out_data=2'b00, in_ready=4'b0000. Release reset -> first transfer appears 1 cycle after the first rising edge.
2. mode=0, sel=2, in_data={d=10,c=11,b=01,a=00}, in_valid=4'b1111, out_ready=1 -> in_ready=4'b0100; next cycle out_data=2'b11, out_ch=2. Then sel=3 -> out_data=2'b10, out_ch=3.
3. mode=0, sel=1, in_valid=4'b1101 -> no grant; in_ready=0; out_valid falls to 0 after drain.
4. mode=1, in_valid=4'b1111, out_ready=1 for 8 cycles -> out_ch sequence 0,1,2,3,0,1,2,3, with out_valid=1 every cycle after the first. in_valid=4'b1010 -> sequence 1,3,1,3.
5. mode=1, out_ready=0 for 3 cycles with word in register -> out_data/out_ch hold; in_ready=0; rr_ptr does not advance. out_ready=1 -> next channel in rotation loads in the same cycle as the drain.
6. Assert rst_n=0 mid-stream (out_valid=1, rr_ptr=2) -> out_valid drops immediately without waiting for clk. After release, the RR scan restarts at channel 0.
